// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for mem_access_arbiter: size codes, FSM states,
// trigger address, beat count and load extension.
package mem_arb_pkg;

  localparam int unsigned MODE_W = 3;
  localparam logic [31:0] TRIGGER_ADDR = 32'h0000_0100;

  typedef enum logic [MODE_W-1:0] {
    SZ_NONE   = 3'd0,
    SZ_WORD   = 3'd1,
    SZ_HALF_S = 3'd2,
    SZ_BYTE_S = 3'd3,
    SZ_HALF_U = 3'd4,
    SZ_BYTE_U = 3'd5
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Zero means the size code is not a legal access.
  function automatic logic [2:0] beat_count(input logic [MODE_W-1:0] mode);
    case (mode)
      SZ_WORD:              return 3'd4;
      SZ_HALF_S, SZ_HALF_U: return 3'd2;
      SZ_BYTE_S, SZ_BYTE_U: return 3'd1;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [MODE_W-1:0] mode);
    case (mode)
      SZ_HALF_S: return {{16{raw[15]}}, raw[15:0]};
      SZ_BYTE_S: return {{24{raw[7]}}, raw[7:0]};
      SZ_HALF_U: return {16'h0000, raw[15:0]};
      SZ_BYTE_U: return {24'h00_0000, raw[7:0]};
      default:   return raw;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer flips to the loser after every grant.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic adv_i,
  output logic sel1_c_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    sel1_c_o = req1_i & (~req0_i | ptr_q);
    ptr_d    = ptr_q;
    if (adv_i && (req0_i || req1_i)) ptr_d = ~sel1_c_o;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter serialising word/half/byte accesses onto a byte-wide RAM.
// Define MISALIGN_CHECK_EN to reject misaligned word/half accesses.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [2:0]        mode0,
  input  logic [2:0]        mode1,
  input  logic [WIDTH-1:0]  addr0,
  input  logic [WIDTH-1:0]  addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic              err0,
  output logic              err1,
  input  logic              trigger,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_e st_q, st_d;
  logic [1:0] beat_q, beat_d;
  logic port_q, port_d, we_q, we_d;
  logic [2:0] mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rfin_c;

  logic ack_d, err_d, ack_port_c;
  logic [WIDTH-1:0] rdata_d;
  logic mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0] mem_wdata_d;

  logic grant_c, sel1_c, sel_we_c, misal_c, reject_c, trig_c, last_beat_c;
  logic [2:0] sel_mode_c, n_sel_c, n_cur_c;
  logic [WIDTH-1:0] sel_addr_c, sel_wdata_c;
  logic [1:0] beat_nxt_c, last_idx_c;

  assign grant_c = (st_q == ST_IDLE) && (req0 || req1);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req0_i  (req0),
    .req1_i  (req1),
    .adv_i   (st_q == ST_IDLE),
    .sel1_c_o(sel1_c)
  );

  assign sel_we_c    = sel1_c ? we1    : we0;
  assign sel_mode_c  = sel1_c ? mode1  : mode0;
  assign sel_addr_c  = sel1_c ? addr1  : addr0;
  assign sel_wdata_c = sel1_c ? wdata1 : wdata0;
  assign n_sel_c     = beat_count(sel_mode_c);
  assign n_cur_c     = beat_count(mode_q);
  assign beat_nxt_c  = beat_q + 2'd1;
  assign last_idx_c  = 2'(n_cur_c - 3'd1);
  assign last_beat_c = ({1'b0, beat_q} == (n_cur_c - 3'd1));

`ifdef MISALIGN_CHECK_EN
  assign misal_c = ((sel_mode_c == SZ_WORD) && (sel_addr_c[1:0] != 2'b00)) ||
                   (((sel_mode_c == SZ_HALF_S) || (sel_mode_c == SZ_HALF_U)) && sel_addr_c[0]);
`else
  assign misal_c = 1'b0;
`endif

  assign reject_c = (n_sel_c == 3'd0) || misal_c;
  assign trig_c   = !sel_we_c && (sel_addr_c == WIDTH'(TRIGGER_ADDR));

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (grant_c) st_d = (reject_c || trig_c) ? ST_DONE : ST_XFER;
      ST_XFER: if (last_beat_c) st_d = ST_LAST;
      ST_LAST: st_d = ST_DONE;
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs.
  always_comb begin
    beat_d      = beat_q;
    port_d      = port_q;
    we_d        = we_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rfin_c      = rbuf_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    ack_port_c  = port_q;
    case (st_q)
      ST_IDLE: if (grant_c) begin
        port_d     = sel1_c;
        we_d       = sel_we_c;
        mode_d     = sel_mode_c;
        addr_d     = sel_addr_c[ADDR_W-1:0];
        wdata_d    = 32'(sel_wdata_c);
        beat_d     = '0;
        rbuf_d     = '0;
        ack_port_c = sel1_c;
        if (reject_c) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else if (trig_c) begin
          ack_d   = 1'b1;
          rdata_d = WIDTH'(trigger);
        end else begin
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we_c;
          mem_addr_d  = sel_addr_c[ADDR_W-1:0];
          mem_wdata_d = sel_wdata_c[7:0];
        end
      end
      ST_XFER: begin
        // RAM answers one cycle late, so this cycle carries the previous beat.
        if (!we_q && (beat_q != 2'd0)) rbuf_d[{2'(beat_q - 2'd1), 3'b000} +: 8] = mem_rdata;
        if (!last_beat_c) begin
          beat_d      = beat_nxt_c;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'(beat_nxt_c);
          mem_wdata_d = 8'(wdata_q >> {beat_nxt_c, 3'b000});
        end
      end
      ST_LAST: begin
        if (!we_q) begin
          rfin_c[{last_idx_c, 3'b000} +: 8] = mem_rdata;
          rdata_d = WIDTH'(load_extend(rfin_c, mode_q));
        end
        ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      mode_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      port_q    <= port_d;
      we_q      <= we_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      ack0      <= ack_d & ~ack_port_c;
      ack1      <= ack_d & ack_port_c;
      err0      <= err_d & ~ack_port_c;
      err1      <= err_d & ack_port_c;
      rdata0    <= ack_port_c ? '0 : rdata_d;
      rdata1    <= ack_port_c ? rdata_d : '0;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= (st_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomised bench for mem_access_arbiter against a byte-array reference model.
module tb_mem_access_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 17;
  localparam int          RAM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req0, req1, we0, we1, trigger, fill;
  logic [2:0] mode0, mode1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic ack0, ack1, err0, err1, mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] ram [RAM_SZ];
  logic [7:0] ref_mem [RAM_SZ];

  mem_access_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .mode0(mode0), .mode1(mode1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .trigger(trigger), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Byte RAM attached to the memory port.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < RAM_SZ; i++) ram[i] <= 8'((i * 37 + 5) & 255);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int beats_of(input logic [2:0] m);
    case (m)
      3'd1:       return 4;
      3'd2, 3'd4: return 2;
      3'd3, 3'd5: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int base, input logic [2:0] m);
    longint v;
    v = 0;
    for (int k = 0; k < beats_of(m); k++)
      v = v | (longint'(ref_mem[(base + k) % RAM_SZ]) << (8 * k));
    if (m == 3'd2 && v >= 32768) v = v - 65536;
    if (m == 3'd3 && v >= 128)   v = v - 256;
    return v[31:0];
  endfunction

  logic [ADDR_W-1:0] b_addr [8];
  int                b_cyc  [8];
  logic              b_we   [8];
  logic [7:0]        b_dat  [8];

  task automatic access(input int tx, input bit port, input bit we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit trig,
                        output logic [31:0] rd, output logic er);
    int n, n_exp, exp_lat, lat, nb, base, nbusy;
    bit misal, rej, trg;
    logic [31:0] exp_rd;
    logic [1:0] acks;
    n = beats_of(mode);
    misal = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (mode == 3'd1 && addr[1:0] != 2'b00) misal = 1'b1;
    if ((mode == 3'd2 || mode == 3'd4) && addr[0]) misal = 1'b1;
`endif
    rej  = (n == 0) || misal;
    trg  = !rej && !we && (addr == 32'h100);
    base = int'(addr & 32'h1FFFF);
    n_exp   = (rej || trg) ? 0 : n;
    exp_lat = (rej || trg) ? 1 : n + 2;
    exp_rd  = (rej || we) ? 32'h0 : trg ? {31'b0, trig} : ref_load(base, mode);
    trigger = trig;
    if (port) begin req1 = 1; we1 = we; mode1 = mode; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1; we0 = we; mode0 = mode; addr0 = addr; wdata0 = wdata; end
    lat = 0; nb = 0; nbusy = 0; rd = '0; er = 1'b0; acks = '0;
    for (int c = 1; c <= 24 && lat == 0; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (mem_en) begin
        if (nb < 8) begin
          b_addr[nb] = mem_addr; b_cyc[nb] = c; b_we[nb] = mem_we; b_dat[nb] = mem_wdata;
        end
        nb++;
      end
      if (ack0 || ack1) begin
        lat = c; acks = {ack1, ack0};
        rd = ack1 ? rdata1 : rdata0;
        er = ack1 ? err1 : err0;
      end
    end
    req0 = 0; req1 = 0;
    check($sformatf("t%0d_latency", tx), 64'(lat), 64'(exp_lat));
    check($sformatf("t%0d_ackport", tx), 64'(acks), port ? 64'd2 : 64'd1);
    check($sformatf("t%0d_rdata", tx), 64'(rd), 64'(exp_rd));
    check($sformatf("t%0d_err", tx), 64'(er), 64'(rej));
    check($sformatf("t%0d_busy", tx), 64'(nbusy), 64'(exp_lat));
    check($sformatf("t%0d_beats", tx), 64'(nb), 64'(n_exp));
    for (int k = 0; k < nb && k < n_exp && k < 8; k++) begin
      check($sformatf("t%0d_b%0d_addr", tx, k), 64'(b_addr[k]), 64'((base + k) % RAM_SZ));
      check($sformatf("t%0d_b%0d_cyc", tx, k), 64'(b_cyc[k]), 64'(k + 1));
      check($sformatf("t%0d_b%0d_we", tx, k), 64'(b_we[k]), 64'(we));
      if (we) check($sformatf("t%0d_b%0d_data", tx, k), 64'(b_dat[k]), 64'((wdata >> (8 * k)) & 32'hFF));
    end
    if (!rej && !trg && we)
      for (int k = 0; k < n; k++) ref_mem[(base + k) % RAM_SZ] = 8'((wdata >> (8 * k)) & 32'hFF);
    @(negedge clk);
    check($sformatf("t%0d_idle", tx), 64'({busy, mem_en, ack0, ack1}), 64'd0);
    if (!rej && !trg && we)
      for (int k = 0; k < n; k++)
        check($sformatf("t%0d_ram%0d", tx, k), 64'(ram[(base + k) % RAM_SZ]), 64'(ref_mem[(base + k) % RAM_SZ]));
  endtask

  int ord [4];
  int acyc [4];
  logic [31:0] ardata [4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd, a;
    logic er;
    int got, sel;
    n_checks = 0; n_errors = 0;
    rst = 1; fill = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; mode0 = '0; mode1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; trigger = 0;
    for (int i = 0; i < RAM_SZ; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    repeat (3) @(negedge clk);
    check("reset_ctl", 64'({ack0, ack1, err0, err1, mem_en, mem_we, busy}), 64'd0);
    check("reset_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    check("reset_rdata", 64'({rdata0, rdata1}), 64'd0);
    fill = 0; rst = 0;
    @(negedge clk);

    // Both ports held: grants alternate starting with port 0.
    req0 = 1; we0 = 0; mode0 = 3'd5; addr0 = 32'h10040;
    req1 = 1; we1 = 0; mode1 = 3'd5; addr1 = 32'h10051;
    got = 0;
    for (int c = 1; c <= 60 && got < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ord[got] = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        acyc[got] = c;
        ardata[got] = ack1 ? rdata1 : rdata0;
        got++;
      end
    end
    req0 = 0; req1 = 0;
    check("dual_count", 64'(got), 64'd4);
    for (int i = 0; i < got; i++) begin
      check($sformatf("dual_order%0d", i), 64'(ord[i]), 64'(i % 2));
      check($sformatf("dual_rdata%0d", i), 64'(ardata[i]),
            64'(ref_load((i % 2 == 1) ? 32'h10051 : 32'h10040, 3'd5)));
      if (i == 0) check("dual_first_cyc", 64'(acyc[0]), 64'd3);
      else check($sformatf("dual_gap%0d", i), 64'(acyc[i] - acyc[i-1]), 64'd4);
    end
    @(negedge clk);
    check("dual_idle", 64'({busy, mem_en, ack0, ack1}), 64'd0);

    access(1, 0, 1, 3'd1, 32'h10000, 32'hDEADBEEF, 0, rd, er);
    access(2, 0, 0, 3'd2, 32'h10002, 32'h0, 0, rd, er);
    check("half_signed", 64'(rd), 64'hFFFFDEAD);
    access(3, 0, 0, 3'd4, 32'h10002, 32'h0, 0, rd, er);
    check("half_unsigned", 64'(rd), 64'h0000DEAD);
    access(4, 0, 0, 3'd3, 32'h10000, 32'h0, 0, rd, er);
    check("byte_signed", 64'(rd), 64'hFFFFFFEF);
    access(5, 1, 0, 3'd5, 32'h10003, 32'h0, 0, rd, er);
    check("byte_unsigned", 64'(rd), 64'h000000DE);
    access(6, 0, 0, 3'd1, 32'h100, 32'h0, 1, rd, er);
    check("trigger_rd", 64'(rd), 64'h1);
    access(7, 1, 0, 3'd7, 32'h10000, 32'h0, 0, rd, er);
    check("bad_mode_err", 64'(er), 64'h1);
    access(8, 1, 0, 3'd1, 32'h1FFFE, 32'h0, 0, rd, er);
`ifndef MISALIGN_CHECK_EN
    check("wrap_b2_addr", 64'(b_addr[2]), 64'h0);
    check("wrap_b3_addr", 64'(b_addr[3]), 64'h1);
`endif

    // Reset during a word store, after beats 0 and 1 have gone out.
    req0 = 1; we0 = 1; mode0 = 3'd1; addr0 = 32'h10020; wdata0 = 32'h11223344;
    @(negedge clk);
    check("rst_beat0", 64'({mem_en, mem_addr, mem_wdata}), 64'({1'b1, 17'h10020, 8'h44}));
    @(negedge clk);
    check("rst_beat1", 64'({mem_en, mem_addr, mem_wdata}), 64'({1'b1, 17'h10021, 8'h33}));
    rst = 1; req0 = 0;
    @(negedge clk);
    check("rst_mid_ctl", 64'({ack0, ack1, err0, err1, mem_en, mem_we, busy}), 64'd0);
    check("rst_mid_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    check("rst_mid_rdata", 64'({rdata0, rdata1}), 64'd0);
    rst = 0;
    @(negedge clk);
    check("rst_after_en", 64'({mem_en, busy}), 64'd0);
    check("rst_ram0", 64'(ram[32'h10020]), 64'h44);
    check("rst_ram1", 64'(ram[32'h10021]), 64'h33);
    check("rst_ram2", 64'(ram[32'h10022]), 64'(ref_mem[32'h10022]));
    check("rst_ram3", 64'(ram[32'h10023]), 64'(ref_mem[32'h10023]));
    ref_mem[32'h10020] = 8'h44;
    ref_mem[32'h10021] = 8'h33;

    for (int t = 0; t < 150; t++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = 32'h100;
        1:       a = 32'h1FFF0 + $urandom_range(0, 15);
        2:       a = 32'h00020100;
        3:       a = $urandom;
        default: a = 32'h10000 + $urandom_range(0, 63);
      endcase
      access(100 + t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), a, $urandom, 1'($urandom_range(0, 1)), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
